mem_port_arbiter: RTL and testbench

Parametrised multi-channel front-end that lets NCH requesters (instruction fetch, data load/store, debug/DMA) share the single port of the synchronous dual-port memory used by the multicycle MIPS core. It sits between the core and the memory. It performs round-robin arbitration and a valid/ready request handshake. It inserts a configurable number of memory wait states and returns a per-channel response pulse with read data.

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_arbiter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port arbiter: FSM encoding,
// alignment width, wait-state counter width and a small alignment helper.
package mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  localparam int ALIGN_BITS = 2;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

  function automatic logic misaligned(input logic [ALIGN_BITS-1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted channel and wraps modulo NCH; the first requester found wins.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_last,
  output logic [NCH-1:0] o_grant,
  output logic [IW-1:0]  o_grant_idx,
  output logic           o_any
);

  int             w_idx;
  logic           w_found;
  logic [NCH-1:0] w_shift;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    w_shift     = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx   = (int'(i_last) + i) % NCH;
      w_shift = i_req >> w_idx;
      if (!w_found && w_shift[0]) begin
        w_found     = 1'b1;
        o_grant     = NCH'(1) << w_idx;
        o_grant_idx = IW'(w_idx);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// NCH-channel front-end sharing one synchronous memory port: round-robin
// grant, WAIT_STATES+1 access cycles, one-cycle response. MEM_PORT_ALIGN_CHECK_EN
// enables the alignment fault path.
//
// Handshake: a channel presents req_valid with stable wr/addr/wdata; the request
// is taken on the rising edge that ends a cycle in which req_ready is high for
// that channel. req_ready is at most one-hot and only ever high in IDLE.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int N           = 32,
  parameter int NCH         = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [NCH-1:0]   req_valid,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH-1:0]   req_wr,
  input  logic [NCH*N-1:0] req_addr,
  input  logic [NCH*N-1:0] req_wdata,
  output logic [NCH-1:0]   rsp_valid,
  output logic [N-1:0]     rsp_rdata,
  output logic             rsp_err,
  output logic [N-1:0]     mem_addr,
  output logic             mem_wr_ena,
  output logic [N-1:0]     mem_wr_data,
  input  logic [N-1:0]     mem_rd_data,
  output logic [1:0]       o_dbg_state
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  mem_state_e       r_state;
  mem_state_e       w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [IW-1:0]    r_last;
  logic             r_wr;
  logic             r_wr_ena;
  logic [N-1:0]     r_addr;
  logic [N-1:0]     r_wdata;

  logic [NCH-1:0]   w_grant;
  logic [IW-1:0]    w_grant_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_misalign;
  logic             w_fault;
  logic             w_sel_wr;
  logic             w_nxt_wr;
  logic [N-1:0]     w_sel_addr;
  logic [N-1:0]     w_sel_wdata;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
    .i_req      (req_valid),
    .i_last     (r_last),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx),
    .o_any      (w_any)
  );

  // Gated by rstb so no grant is ever advertised while reset is held.
  assign w_accept  = rstb && (r_state == ST_IDLE) && w_any;
  assign req_ready = w_accept ? w_grant : '0;
  assign w_sel_wr  = |(req_wr & w_grant);
  assign w_nxt_wr  = w_accept ? w_sel_wr : r_wr;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_grant[k]) begin
        w_sel_addr  = req_addr[k*N +: N];
        w_sel_wdata = req_wdata[k*N +: N];
      end
    end
  end

`ifdef MEM_PORT_ALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = misaligned(w_sel_addr[ALIGN_BITS-1:0]);
  assign w_fault    = r_err;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)         r_err <= 1'b0;
    else if (w_accept) r_err <= w_misalign;
  end
`else
  assign w_misalign = 1'b0;
  assign w_fault    = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_state = w_misalign ? ST_RESP : ST_ACCESS;
          w_nxt_cnt   = w_misalign ? '0 : CNT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) w_nxt_state = ST_RESP;
        else             w_nxt_cnt   = r_cnt - 1'b1;
      end
      ST_RESP:  w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= IW'(NCH - 1);
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr_ena <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      // Strobe is registered so it lines up with the last ACCESS cycle.
      r_wr_ena <= (w_nxt_state == ST_ACCESS) && (w_nxt_cnt == '0) && w_nxt_wr;
      if (w_accept) begin
        r_last  <= w_grant_idx;
        r_wr    <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;
  assign mem_wr_ena  = r_wr_ena;
  assign rsp_valid   = (r_state == ST_RESP) ? (NCH'(1) << r_last) : '0;
  assign rsp_err     = (r_state == ST_RESP) && w_fault;
  assign rsp_rdata   = ((r_state == ST_RESP) && !r_wr && !w_fault) ? mem_rd_data : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized plus directed bench for mem_port_arbiter (NCH=4, WAIT_STATES=3)
// against a transaction-level model of grant order, latency and memory contents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N   = 32;
  localparam int NCH = 4;
  localparam int WS  = 3;
`ifdef MEM_PORT_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]   req_valid, req_ready, req_wr, rsp_valid;
  logic [NCH*N-1:0] req_addr, req_wdata;
  logic [N-1:0]     rsp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic             rsp_err, mem_wr_ena;
  logic [1:0]       dbg_state;

  logic [NCH-1:0] drv_valid = '0;
  logic [NCH-1:0] drv_wr    = '0;
  logic [NCH-1:0] sticky    = '0;
  logic [NCH-1:0] acc       = '0;
  logic [N-1:0]   drv_addr  [NCH];
  logic [N-1:0]   drv_wdata [NCH];
  bit             mon_en = 1'b0;
  bit             rnd_en = 1'b0;
  bit             mem_init = 1'b0;
  int             cyc = 0;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      req_addr[k*N +: N]  = drv_addr[k];
      req_wdata[k*N +: N] = drv_wdata[k];
    end
  end
  assign req_valid = drv_valid;
  assign req_wr    = drv_wr;

  mem_port_arbiter #(.N(N), .NCH(NCH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .o_dbg_state(dbg_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory behind the port ----------------
  function automatic logic [N-1:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 | i);
  endfunction

  logic [N-1:0] dmem [16];
  logic [N-1:0] ref_mem [16];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_val(i);
    end else if (mem_wr_ena) begin
      dmem[mem_addr[5:2]] <= mem_wr_data;
    end
    mem_rd_data <= dmem[mem_addr[5:2]];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int           m_last, m_free_at, m_rsp_due, m_rsp_ch, m_wr_due, m_pw_due, m_pw_idx;
  bit           m_rsp_pend, m_wr_pend, m_pw_v, m_exp_err;
  logic [N-1:0] m_wr_addr, m_wr_data, m_pw_data;
  logic [N-1:0] exp_q[$];
  int           grant_log[$];
  logic [N-1:0] last_rsp [NCH];

  task automatic model_reset();
    m_last     = NCH - 1;
    m_free_at  = 0;
    m_rsp_pend = 1'b0;
    m_wr_pend  = 1'b0;
    m_pw_v     = 1'b0;
    exp_q.delete();
    grant_log.delete();
  endtask

  always @(negedge clk) begin
    int win;
    logic [NCH-1:0] exp_rdy, exp_rv;
    bit misal, exp_we;
    if (mon_en) begin
      if (m_pw_v && cyc > m_pw_due) begin
        ref_mem[m_pw_idx] = m_pw_data;
        m_pw_v = 1'b0;
      end
      win = -1;
      exp_rdy = '0;
      if (cyc >= m_free_at) begin
        for (int i = 1; i <= NCH; i++) begin
          int k;
          k = (m_last + i) % NCH;
          if (win < 0 && drv_valid[k]) win = k;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);

      exp_rv = '0;
      if (m_rsp_pend && cyc == m_rsp_due) exp_rv[m_rsp_ch] = 1'b1;
      check_eq("rsp_valid", rsp_valid, exp_rv);
      if (m_rsp_pend && cyc == m_rsp_due) begin
        check_eq("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check_eq("rsp_err", rsp_err, m_exp_err);
        last_rsp[m_rsp_ch] = rsp_rdata;
        m_rsp_pend = 1'b0;
      end else begin
        check_eq("rsp_idle", {rsp_rdata, rsp_err}, '0);
      end

      exp_we = m_wr_pend && (cyc == m_wr_due);
      check_eq("mem_wr_ena", mem_wr_ena, exp_we);
      if (exp_we) begin
        check_eq("mem_addr", mem_addr, m_wr_addr);
        check_eq("mem_wr_data", mem_wr_data, m_wr_data);
        m_wr_pend = 1'b0;
      end

      if (win >= 0) begin
        m_last = win;
        grant_log.push_back(win);
        acc[win] = 1'b1;
        misal = ALIGN_CHK && (drv_addr[win][1:0] != 2'b00);
        m_rsp_pend = 1'b1;
        m_rsp_ch   = win;
        m_exp_err  = misal;
        if (misal) begin
          m_rsp_due = cyc + 1;
          m_free_at = cyc + 2;
          exp_q.push_back('0);
        end else begin
          m_rsp_due = cyc + WS + 2;
          m_free_at = cyc + WS + 3;
          if (drv_wr[win]) begin
            exp_q.push_back('0);
            m_wr_pend = 1'b1;
            m_wr_due  = cyc + WS + 1;
            m_wr_addr = drv_addr[win];
            m_wr_data = drv_wdata[win];
            m_pw_v    = 1'b1;
            m_pw_due  = m_wr_due;
            m_pw_idx  = int'(drv_addr[win][5:2]);
            m_pw_data = drv_wdata[win];
          end else begin
            exp_q.push_back(ref_mem[drv_addr[win][5:2]]);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        acc[k] = 1'b0;
        if (!sticky[k]) drv_valid[k] = 1'b0;
      end
    end
    if (rnd_en) begin
      for (int k = 0; k < NCH; k++) begin
        if (!drv_valid[k] && $urandom_range(0, 3) == 0) begin
          drv_wr[k]    = 1'($urandom_range(0, 1));
          drv_addr[k]  = N'($urandom_range(0, 15) * 4);
          if ($urandom_range(0, 7) == 0) drv_addr[k][1:0] = 2'($urandom_range(1, 3));
          drv_wdata[k] = $urandom;
          drv_valid[k] = 1'b1;
        end
      end
    end
  end

  task automatic issue(input int ch, input bit wr, input logic [N-1:0] addr, input logic [N-1:0] data);
    drv_wr[ch]    = wr;
    drv_addr[ch]  = addr;
    drv_wdata[ch] = data;
    drv_valid[ch] = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((drv_valid != '0 || m_rsp_pend || cyc < m_free_at) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_done", (n < limit), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_quiesce();
    mon_en    = 1'b0;
    drv_valid = '0;
    sticky    = '0;
    acc       = '0;
    model_reset();
  endtask

  task automatic apply_reset();
    reset_quiesce();
    rstb = 1'b0;
    drv_valid[0] = 1'b1;
    #1;
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_mem_wr", {mem_wr_ena, mem_wr_data}, '0);
    drv_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rstb   = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;
    bit seen;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int k = 0; k < NCH; k++) begin
      drv_addr[k]  = '0;
      drv_wdata[k] = '0;
      last_rsp[k]  = '0;
    end
    #2;
    mem_init = 1'b1;
    apply_reset();
    mem_init = 1'b0;

    // single read of a known word
    issue(0, 1'b0, 32'h10, 32'h0);
    drain(50);
    check_eq("read_0x10", last_rsp[0], 32'hDEADBEEF);

    // write from ch1, read back from ch0
    issue(1, 1'b1, 32'h20, 32'hCAFEF00D);
    drain(50);
    issue(0, 1'b0, 32'h20, 32'h0);
    drain(50);
    check_eq("raw_0x20", last_rsp[0], 32'hCAFEF00D);

    // unaligned read: fault response or plain access depending on build
    issue(0, 1'b0, 32'h13, 32'h0);
    drain(50);
    check_eq("read_0x13", last_rsp[0], ALIGN_CHK ? 32'h0 : 32'hDEADBEEF);

    // reset during the final ACCESS cycle of a write
    issue(2, 1'b1, 32'h30, 32'h5555AAAA);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_wr_ena) seen = 1'b1;
    end
    check_eq("wr_strobe_seen", seen, 1);
    #1;
    reset_quiesce();
    rstb = 1'b0;
    #1;
    check_eq("rst_we_drop", mem_wr_ena, 0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_rsp", rsp_valid, '0);
    end
    check_eq("rst_dmem_kept", dmem[12], ref_mem[12]);
    @(posedge clk);
    #1;
    rstb   = 1'b1;
    mon_en = 1'b1;
    issue(0, 1'b0, 32'h0, 32'h0);
    issue(2, 1'b0, 32'h8, 32'h0);
    drain(50);
    check_eq("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check_eq("post_rst_first", grant_log[0], 0);

    // continuous requests on ch1 and ch3 from last_grant=3
    apply_reset();
    sticky = 4'b1010;
    issue(1, 1'b0, 32'h4, 32'h0);
    issue(3, 1'b0, 32'hC, 32'h0);
    n = 0;
    while (grant_log.size() < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    sticky = '0;
    check_eq("contend_done", (n < 100), 1);
    drain(50);
    if (grant_log.size() >= 3) begin
      check_eq("contend_g0", grant_log[0], 1);
      check_eq("contend_g1", grant_log[1], 3);
      check_eq("contend_g2", grant_log[2], 1);
    end

    // randomized traffic
    rnd_en = 1'b1;
    repeat (1500) @(posedge clk);
    rnd_en = 1'b0;
    drain(200);
    check_eq("rand_grants", (grant_log.size() > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
